// File: rtl/pipe_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests
// under a credit limit, and buffers returned words in a small FIFO for IF/ID.
module pipe_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_data_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic [31:0]     inst_o
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];

  logic [XLEN-1:0] redirect_tgt;
  logic [CW:0]     in_use;
  logic            grant;
  logic            push;
  logic            pop;
  logic            unused_pc_lsb;

  assign redirect_tgt  = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  // Every request in flight owns a FIFO slot, so a push can never overflow.
  assign in_use     = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_o = rst_n_i && !redirect_i && (in_use < (CW + 1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign grant = imem_req_o && imem_gnt_i;
  assign push  = imem_rvalid_i && !redirect_i && (drop_cnt_q == '0);
  assign pop   = out_valid_o && out_ready_i;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
    count_d       = count_q + CW'(push) - CW'(pop);

    if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
    if (imem_rvalid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    if (push) begin
      resp_pc_d = resp_pc_q + PC_STEP;
      wr_ptr_d  = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    // Everything still in flight after this edge is stale, including any
    // responses already marked for dropping by an earlier redirect.
    if (redirect_i) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      drop_cnt_d = outstanding_q - CW'(imem_rvalid_i);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign out_valid_o = (count_q != '0);
  assign pc_data_o   = out_valid_o ? pc_mem_q[rd_ptr_q] : '0;
  assign pc_next_o   = out_valid_o ? pc_mem_q[rd_ptr_q] + PC_STEP : '0;
  assign inst_o      = out_valid_o ? inst_mem_q[rd_ptr_q] : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(push && (count_q == CW'(DEPTH))))
        else $fatal(1, "pipe_fetch: push into full instruction FIFO");
    end
  end
`endif

endmodule
